multicycle_controller: RTL and testbench

- Moore-style FSM sequencing a multicycle MIPS datapath: shared instruction/data memory port, one ALU, instruction register (IR), PC.
- Replaces the single-cycle combinational decoder in the multicycle core variant.
- Decodes OP/Funct from the IR, steps each instruction through FETCH..writeback, and stalls on a memory-ready handshake.

---
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore-style sequencer for the multicycle MIPS datapath: steps each instruction
// from FETCH through writeback and stalls on the shared memory port's ready signal.
module multicycle_controller #(
   parameter bit         MEM_WAIT_EN = 1'b1,
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] OP,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       Mem2Reg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       Illegal,
   output logic       Retire,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BEQ    = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   state_t state;
   logic   mem_ready;
   logic   funct_ok;
   logic   op_legal;
   logic   pc_write;
   logic   branch;

   // With waiting disabled every memory access is treated as single-cycle.
   assign mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;
   assign State     = state;

   always_comb begin
      case (Funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
         default:                               funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      case (OP)
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
         OP_RTYPE:                            op_legal = funct_ok;
         default:                             op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= state_t'(RESET_STATE);
      end else begin
         case (state)
            FETCH:  if (mem_ready) state <= DECODE;
            DECODE: begin
               if (!op_legal) begin
                  state <= FETCH;
               end else begin
                  case (OP)
                     OP_LW, OP_SW: state <= MEMADR;
                     OP_RTYPE:     state <= EXEC;
                     OP_BEQ:       state <= BEQ;
                     OP_ADDI:      state <= ADDIEX;
                     OP_J:         state <= JUMP;
                     default:      state <= FETCH;
                  endcase
               end
            end
            MEMADR: state <= (OP == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state <= MEMWB;
            MEMWR:  if (mem_ready) state <= FETCH;
            EXEC:   state <= ALUWB;
            ADDIEX: state <= ADDIWB;
            default: state <= FETCH;
         endcase
      end
   end

   always_comb begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      Mem2Reg    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b010;
      PCSrc      = 2'b00;
      Illegal    = 1'b0;
      Retire     = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcB  = 2'b01;
            IRWrite  = mem_ready;
            pc_write = mem_ready;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            Illegal = !op_legal;
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD: IorD = 1'b1;
         MEMWB: begin
            Mem2Reg  = 1'b1;
            RegWrite = 1'b1;
            Retire   = 1'b1;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            Retire   = mem_ready;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            case (Funct)
               FN_SUB:  ALUControl = 3'b110;
               FN_AND:  ALUControl = 3'b000;
               FN_OR:   ALUControl = 3'b001;
               FN_SLT:  ALUControl = 3'b111;
               default: ALUControl = 3'b010;
            endcase
         end
         ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            Retire   = 1'b1;
         end
         BEQ: begin
            ALUSrcA    = 1'b1;
            ALUControl = 3'b110;
            PCSrc      = 2'b01;
            branch     = 1'b1;
            Retire     = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         ADDIWB: begin
            RegWrite = 1'b1;
            Retire   = 1'b1;
         end
         JUMP: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
            Retire   = 1'b1;
         end
         default: ;
      endcase
      PCEn = pc_write | (branch & Zero);
      // Reset must never let a write or pulse escape, even mid-stall.
      if (RST) begin
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         PCEn     = 1'b0;
         Illegal  = 1'b0;
         Retire   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step lists model the controller,
// with directed instruction checks followed by randomized instructions, stalls and resets.
module tb_multicycle_controller;

   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem2reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] pc_src;
      logic       pc_en;
      logic       illegal;
      logic       retire;
   } outs_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic       clk = 1'b0;
   logic       RST = 1'b1;
   logic [5:0] OP = '0;
   logic [5:0] Funct = '0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       IorD, MemWrite, IRWrite, RegDst, Mem2Reg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUControl;
   logic       PCEn, Illegal, Retire;
   logic [3:0] State;

   int checks = 0;
   int errors = 0;

   logic [5:0] cur_op = '0;
   logic [5:0] cur_fn = '0;
   int         seq[$];
   logic [5:0] plan_op[$];
   logic [5:0] plan_fn[$];
   logic [5:0] r_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   outs_t      g;
   logic [3:0] g_state;

   multicycle_controller #(.MEM_WAIT_EN(1'b1), .RESET_STATE(4'd0)) dut (
      .CLK(clk), .RST(RST), .OP(OP), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .Mem2Reg(Mem2Reg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal),
      .Retire(Retire), .State(State)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         if (errors <= 30) $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
      bit fn_ok;
      fn_ok = 1'b0;
      foreach (r_fn[i]) if (r_fn[i] == fn) fn_ok = 1'b1;
      return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_ADDI) ||
             (op == OP_J) || ((op == OP_R) && fn_ok);
   endfunction

   function automatic logic [2:0] fn_ctl(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // The step list of one instruction, as the sequence of states it visits.
   function automatic void build_seq();
      seq.delete();
      seq.push_back(0);
      seq.push_back(1);
      if (is_legal(cur_op, cur_fn)) begin
         case (cur_op)
            OP_LW:   begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            OP_SW:   begin seq.push_back(2); seq.push_back(5); end
            OP_R:    begin seq.push_back(6); seq.push_back(7); end
            OP_BEQ:  seq.push_back(8);
            OP_ADDI: begin seq.push_back(9); seq.push_back(10); end
            default: seq.push_back(11);
         endcase
      end
   endfunction

   function automatic void new_instr();
      int k;
      if (plan_op.size() > 0) begin
         cur_op = plan_op.pop_front();
         cur_fn = plan_fn.pop_front();
      end else begin
         cur_fn = 6'($urandom);
         case ($urandom_range(0, 7))
            0: cur_op = OP_LW;
            1: cur_op = OP_SW;
            2, 3: begin
               cur_op = OP_R;
               k = $urandom_range(0, 5);
               if (k < 5) cur_fn = r_fn[k];
            end
            4: cur_op = OP_BEQ;
            5: cur_op = OP_ADDI;
            6: cur_op = OP_J;
            default: cur_op = 6'($urandom);
         endcase
      end
      build_seq();
   endfunction

   function automatic outs_t expect_outs(input int st, input bit rdy, input bit rst_v, input bit z);
      outs_t o;
      o = '0;
      o.alu_control = 3'b010;
      case (st)
         0: begin o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; end
         1: begin o.alu_src_b = 2'b11; o.illegal = !is_legal(cur_op, cur_fn); end
         2: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         3: o.iord = 1'b1;
         4: begin o.mem2reg = 1'b1; o.reg_write = 1'b1; o.retire = 1'b1; end
         5: begin o.iord = 1'b1; o.mem_write = 1'b1; o.retire = rdy; end
         6: begin o.alu_src_a = 1'b1; o.alu_control = fn_ctl(cur_fn); end
         7: begin o.reg_dst = 1'b1; o.reg_write = 1'b1; o.retire = 1'b1; end
         8: begin o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.pc_src = 2'b01;
                  o.pc_en = z; o.retire = 1'b1; end
         9: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         10: begin o.reg_write = 1'b1; o.retire = 1'b1; end
         default: begin o.pc_src = 2'b10; o.pc_en = 1'b1; o.retire = 1'b1; end
      endcase
      if (rst_v) begin
         o.mem_write = 1'b0; o.ir_write = 1'b0; o.reg_write = 1'b0;
         o.pc_en = 1'b0; o.illegal = 1'b0; o.retire = 1'b0;
      end
      return o;
   endfunction

   // One clock: drive inputs, compare every output against the model, then step the model.
   task automatic cycle(input bit rst_v, input bit rdy, input bit z);
      outs_t e;
      bit    stall;
      @(negedge clk);
      RST = rst_v; MemReady = rdy; Zero = z; OP = cur_op; Funct = cur_fn;
      #1;
      g = {IorD, MemWrite, IRWrite, RegDst, Mem2Reg, RegWrite, ALUSrcA, ALUSrcB,
           ALUControl, PCSrc, PCEn, Illegal, Retire};
      g_state = State;
      e = expect_outs(seq[0], rdy, rst_v, z);
      check("state", 32'(g_state), 32'(seq[0]));
      check("outputs", 32'(g), 32'(e));
      @(posedge clk);
      stall = ((seq[0] == 0) || (seq[0] == 3) || (seq[0] == 5)) && !rdy;
      if (rst_v) begin
         build_seq();
      end else if (!stall) begin
         void'(seq.pop_front());
         if (seq.size() == 0) new_instr();
      end
   endtask

   initial begin
      int cnt_a, cnt_b, cnt_c;
      logic [2:0] r_ctl[5] = '{3'b111, 3'b010, 3'b110, 3'b000, 3'b001};
      logic [5:0] r_seq[5] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};

      plan_op.push_back(OP_LW); plan_fn.push_back(6'd0);
      plan_op.push_back(OP_SW); plan_fn.push_back(6'd0);
      foreach (r_seq[i]) begin plan_op.push_back(OP_R); plan_fn.push_back(r_seq[i]); end
      plan_op.push_back(OP_BEQ); plan_fn.push_back(6'd0);
      plan_op.push_back(OP_BEQ); plan_fn.push_back(6'd0);
      plan_op.push_back(OP_J); plan_fn.push_back(6'd0);
      plan_op.push_back(6'b111111); plan_fn.push_back(6'd0);
      plan_op.push_back(OP_LW); plan_fn.push_back(6'd0);

      RST = 1'b1;
      @(posedge clk);
      @(posedge clk);
      new_instr();

      // lw: 0,1,2,3,4 with a single retire and register write only in MEMWB
      cnt_a = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         check("lw_state", 32'(g_state), i);
         check("lw_regwrite", 32'(g.reg_write), 32'(i == 4));
         check("lw_mem2reg", 32'(g.mem2reg), 32'(i == 4));
         cnt_a += int'(g.retire);
      end
      check("lw_retire_count", cnt_a, 1);

      // sw with three stall cycles in MEMWR
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0, (i < 3) || (i == 6), 1'b0);
         if (i == 0) check("sw_fetch", 32'(g_state), 0);
         if (i >= 3) begin
            cnt_a += int'(g.mem_write);
            cnt_b += int'(g.iord);
            check("sw_retire", 32'(g.retire), 32'(i == 6));
         end
         cnt_c += int'(g.reg_write);
      end
      check("sw_memwrite_cycles", cnt_a, 4);
      check("sw_iord_cycles", cnt_b, 4);
      check("sw_regwrite_cycles", cnt_c, 0);

      // R-type: slt, add, sub, and, or
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            if (i == 2) check("rtype_alu_control", 32'(g.alu_control), 32'(r_ctl[k]));
            if (i == 3) check("rtype_writeback", 32'({g_state, g.reg_dst, g.reg_write}), 32'({4'd7, 2'b11}));
         end
      end

      // beq taken then not taken
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, i == 2);
         if (i == 2) check("beq_taken", 32'({g_state, g.pc_src, g.pc_en}), 32'({4'd8, 2'b01, 1'b1}));
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (i == 2) check("beq_not_taken", 32'({g_state, g.pc_en}), 32'({4'd8, 1'b0}));
      end

      // j
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (i == 2) check("jump", 32'({g_state, g.pc_src, g.pc_en}), 32'({4'd11, 2'b10, 1'b1}));
      end

      // unsupported opcode
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (i == 1) begin
            check("illegal_pulse", 32'({g_state, g.illegal}), 32'({4'd1, 1'b1}));
            check("illegal_no_writes",
                  32'({g.mem_write, g.ir_write, g.reg_write, g.pc_en, g.retire}), 0);
         end
      end

      // reset while stalled in MEMRD
      cycle(1'b0, 1'b1, 1'b0);
      check("after_illegal_fetch", 32'(g_state), 0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      check("memrd_stall", 32'(g_state), 3);
      cycle(1'b1, 1'b1, 1'b0);
      check("rst_first", 32'({g_state, g.ir_write, g.pc_en}), 32'({4'd3, 2'b00}));
      cycle(1'b1, 1'b1, 1'b0);
      check("rst_second", 32'({g_state, g.ir_write, g.pc_en}), 32'({4'd0, 2'b00}));
      cycle(1'b0, 1'b1, 1'b0);
      check("post_reset_fetch", 32'({g_state, g.ir_write, g.pc_en, g.alu_src_b}),
            32'({4'd0, 2'b11, 2'b01}));

      // randomized instruction mix with stalls and occasional resets
      for (int n = 0; n < 4000; n++) begin
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
